// File: rtl/peri_timer_bank_if.sv
// Register-slave bus for the peripheral timer bank: request/acknowledge handshake
// with word addressing, byte-enabled writes and registered read data.
interface peri_timer_bank_if;
    logic        reg_cs;
    logic        reg_wr;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    modport master (
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        output reg_rdata, reg_ack
    );
endinterface

// File: rtl/peri_timer_bank.sv
// Bank of NUM_TMR down-counters with a shared 1us/1ms timebase, per-timer mode and
// tick-source select, sticky W1C interrupt status with mask, and a register slave.
module peri_timer_bank #(
    parameter int          NUM_TMR = 4,
    parameter int          TMR_W   = 24,
    parameter logic [15:0] US_DIV  = 16'd49
) (
    input  logic               mclk,
    input  logic               reset,
    peri_timer_bank_if.slave   bus,
    output logic               pulse_1us,
    output logic               pulse_1ms,
    output logic [NUM_TMR-1:0] timer_intr
);

    logic                             ack_reg;
    logic [31:0]                      rdata_reg;
    logic [31:0]                      rd_val;
    logic                             access;
    logic                             wr_stb;
    logic                             tmr_space;
    logic [3:0]                       tmr_idx;
    logic [15:0]                      us_div_reg;
    logic [15:0]                      us_cnt_reg;
    logic [9:0]                       ms_cnt_reg;
    logic [NUM_TMR-1:0]               stat_reg;
    logic [NUM_TMR-1:0]               mask_reg;
    logic [NUM_TMR-1:0]               intr_reg;
    logic [NUM_TMR-1:0]               stat_set;
    logic [NUM_TMR-1:0]               stat_clr;
    logic [NUM_TMR-1:0][TMR_W-1:0]    count_all;
    logic [NUM_TMR-1:0][4:0]          cfg_all;

    // An access starts whenever cs is high and we are not already acknowledging.
    assign access    = bus.reg_cs && !ack_reg;
    assign wr_stb    = access && bus.reg_wr;
    assign tmr_space = (bus.reg_addr >= 5'd4) && (bus.reg_addr <= 5'd19);
    assign tmr_idx   = bus.reg_addr[4:1] - 4'd2;

    assign pulse_1us = (us_cnt_reg == us_div_reg);
    assign pulse_1ms = pulse_1us && (ms_cnt_reg == 10'd999);

    always_ff @(posedge mclk) begin
        if (reset) begin
            us_div_reg <= US_DIV;
            us_cnt_reg <= '0;
            ms_cnt_reg <= '0;
        end else if (wr_stb && bus.reg_addr == 5'd0) begin
            us_div_reg[15:8] <= bus.reg_be[1] ? bus.reg_wdata[15:8] : us_div_reg[15:8];
            us_div_reg[7:0]  <= bus.reg_be[0] ? bus.reg_wdata[7:0]  : us_div_reg[7:0];
            us_cnt_reg       <= '0;
            ms_cnt_reg       <= '0;
        end else if (pulse_1us) begin
            us_cnt_reg <= '0;
            ms_cnt_reg <= (ms_cnt_reg == 10'd999) ? 10'd0 : ms_cnt_reg + 10'd1;
        end else begin
            us_cnt_reg <= us_cnt_reg + 16'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_TMR; gi++) begin : g_tmr
        logic             en_reg;
        logic [1:0]       mode_reg;
        logic [1:0]       tick_sel_reg;
        logic [TMR_W-1:0] count_reg;
        logic [TMR_W-1:0] load_reg;
        logic [TMR_W-1:0] tval_merge;
        logic             tick;
        logic             hit;
        logic             tcfg_wr;
        logic             tval_wr;

        assign hit     = wr_stb && tmr_space && (tmr_idx == 4'(gi));
        assign tcfg_wr = hit && !bus.reg_addr[0];
        assign tval_wr = hit && bus.reg_addr[0];

        always_comb begin
            case (tick_sel_reg)
                2'd0:    tick = 1'b1;
                2'd1:    tick = pulse_1us;
                2'd2:    tick = pulse_1ms;
                default: tick = 1'b0;
            endcase
        end

        always_comb begin
            tval_merge = load_reg;
            for (int j = 0; j < TMR_W; j++) begin
                if (bus.reg_be[j/8]) tval_merge[j] = bus.reg_wdata[j];
            end
        end

        // A TVAL write in the same cycle suppresses both the decrement and the expiry.
        assign stat_set[gi] = en_reg && tick && (count_reg == '0) && !tval_wr;

        always_ff @(posedge mclk) begin
            if (reset) begin
                en_reg       <= 1'b0;
                mode_reg     <= 2'd0;
                tick_sel_reg <= 2'd0;
                count_reg    <= '0;
                load_reg     <= '0;
            end else begin
                if (tval_wr) begin
                    load_reg  <= tval_merge;
                    count_reg <= tval_merge;
                end else if (en_reg && tick) begin
                    if (count_reg != '0) begin
                        count_reg <= count_reg - 1'b1;
                    end else begin
                        case (mode_reg)
                            2'd1:    count_reg <= load_reg;
                            2'd2:    count_reg <= '1;
                            default: en_reg <= 1'b0;
                        endcase
                    end
                end
                // Placed last so a software en=0 overrides the one-shot self-clear.
                if (tcfg_wr && bus.reg_be[0]) begin
                    en_reg       <= bus.reg_wdata[0];
                    mode_reg     <= bus.reg_wdata[2:1];
                    tick_sel_reg <= bus.reg_wdata[4:3];
                end
            end
        end

        assign count_all[gi] = count_reg;
        assign cfg_all[gi]   = {tick_sel_reg, mode_reg, en_reg};
    end

    assign stat_clr = (wr_stb && bus.reg_addr == 5'd1 && bus.reg_be[0])
                      ? bus.reg_wdata[NUM_TMR-1:0] : '0;

    always_ff @(posedge mclk) begin
        if (reset) begin
            stat_reg <= '0;
            mask_reg <= '0;
            intr_reg <= '0;
        end else begin
            stat_reg <= (stat_reg & ~stat_clr) | stat_set;
            if (wr_stb && bus.reg_addr == 5'd2 && bus.reg_be[0]) begin
                mask_reg <= bus.reg_wdata[NUM_TMR-1:0];
            end
            intr_reg <= stat_reg & mask_reg;
        end
    end

    assign timer_intr = intr_reg;

    always_comb begin
        rd_val = '0;
        case (bus.reg_addr)
            5'd0: rd_val = 32'(us_div_reg);
            5'd1: rd_val = 32'(stat_reg);
            5'd2: rd_val = 32'(mask_reg);
            default: begin
                for (int k = 0; k < NUM_TMR; k++) begin
                    if (tmr_space && tmr_idx == 4'(k)) begin
                        rd_val = bus.reg_addr[0] ? 32'(count_all[k]) : 32'(cfg_all[k]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            ack_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            ack_reg   <= access;
            rdata_reg <= (access && !bus.reg_wr) ? rd_val : 32'd0;
        end
    end

    assign bus.reg_ack   = ack_reg;
    assign bus.reg_rdata = rdata_reg;

endmodule

// File: tb/tb_peri_timer_bank.sv
// Randomised self-checking bench for peri_timer_bank against an arithmetic model of
// timebase period, timer count trajectories and interrupt timing.
module tb_peri_timer_bank;

    logic       mclk = 1'b0;
    logic       reset = 1'b1;
    logic       pulse_1us;
    logic       pulse_1ms;
    logic [3:0] timer_intr;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    peri_timer_bank_if bus_if ();

    peri_timer_bank #(.NUM_TMR(4), .TMR_W(24), .US_DIV(16'd49)) dut (
        .mclk       (mclk),
        .reset      (reset),
        .bus        (bus_if),
        .pulse_1us  (pulse_1us),
        .pulse_1ms  (pulse_1ms),
        .timer_intr (timer_intr)
    );

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc <= cyc + 1;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    // Expected count after n mclk ticks from load value ld in the given mode.
    function automatic longint exp_count(int mode, longint ld, longint n);
        if (mode == 1) return ld - (n % (ld + 1));
        if (mode == 2) return (ld - n) & 64'hFF_FFFF;
        return (n <= ld) ? ld - n : 0;
    endfunction

    // Stat bit seen by a read at edge r after a W1C at edge w, expiries every per edges from pb.
    function automatic bit stat_after(int pb, int per, int w, int r);
        bit s;
        s = ((w - pb) > 0) && (((w - pb) % per) == 0);
        for (int e = w + 1; e < r; e++) if (((e - pb) % per) == 0) s = 1'b1;
        return s;
    endfunction

    task automatic bus_access(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic ack, output int edge_n);
        @(negedge mclk);
        bus_if.reg_cs    = 1'b1;
        bus_if.reg_wr    = wr;
        bus_if.reg_addr  = addr;
        bus_if.reg_wdata = wdata;
        bus_if.reg_be    = 4'hF;
        @(posedge mclk);
        #1;
        edge_n = cyc;
        ack    = bus_if.reg_ack;
        rdata  = bus_if.reg_rdata;
        @(negedge mclk);
        bus_if.reg_cs = 1'b0;
    endtask

    task automatic bus_wr(input logic [4:0] addr, input logic [31:0] wdata, output int edge_n);
        logic [31:0] d;
        logic        a;
        bus_access(1'b1, addr, wdata, d, a, edge_n);
    endtask

    task automatic bus_rd(input logic [4:0] addr, output logic [31:0] rdata, output int edge_n);
        logic a;
        bus_access(1'b0, addr, 32'd0, rdata, a, edge_n);
    endtask

    task automatic do_reset();
        @(negedge mclk);
        reset = 1'b1;
        bus_if.reg_cs = 1'b0;
        repeat (2) @(posedge mclk);
        @(negedge mclk);
        reset = 1'b0;
    endtask

    task automatic wait_rise(input int b, input int bound, output int at);
        logic seen_low;
        seen_low = !timer_intr[b];
        at = -1;
        for (int k = 0; k < bound; k++) begin
            @(posedge mclk);
            #1;
            if (timer_intr[b] && seen_low) begin
                at = cyc;
                break;
            end
            if (!timer_intr[b]) seen_low = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int          e;
        do_reset();
        n_cmp++;
        if ({pulse_1us, pulse_1ms, timer_intr} !== 6'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 000000", {pulse_1us, pulse_1ms, timer_intr});
        end
        bus_rd(5'd0, d, e);
        n_cmp++;
        if (d !== 32'd49) begin
            n_err++;
            $display("FAIL reset_glbl_cfg: got %0d required 49", d);
        end
        for (int a = 1; a < 20; a++) begin
            bus_rd(5'(a), d, e);
            n_cmp++;
            if (d !== 32'd0) begin
                n_err++;
                $display("FAIL reset_reg addr=%0d: got %h required 0", a, d);
            end
        end
        // A write presented while reset is high must be dropped and never acked.
        @(negedge mclk);
        reset = 1'b1;
        bus_if.reg_cs = 1'b1; bus_if.reg_wr = 1'b1; bus_if.reg_addr = 5'd5;
        bus_if.reg_wdata = 32'h55; bus_if.reg_be = 4'hF;
        @(posedge mclk);
        #1;
        n_cmp++;
        if (bus_if.reg_ack !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_access_ack: got %b required 0", bus_if.reg_ack);
        end
        @(negedge mclk);
        bus_if.reg_cs = 1'b0;
        reset = 1'b0;
        bus_rd(5'd5, d, e);
        n_cmp++;
        if (d !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid_access_tval: got %h required 0", d);
        end
        $display("test_reset done");
    endtask

    task automatic test_timebase();
        int pw;
        int errs;
        do_reset();
        bus_wr(5'd0, 32'd4, pw);
        errs = 0;
        for (int c = 0; c < 5010; c++) begin
            int rel;
            logic exp_us;
            logic exp_ms;
            @(posedge mclk);
            #1;
            rel    = cyc - pw;
            exp_us = ((rel % 5) == 4);
            exp_ms = (rel >= 4999) && (((rel - 4999) % 5000) == 0);
            n_cmp++;
            if ({pulse_1us, pulse_1ms} !== {exp_us, exp_ms}) begin
                n_err++;
                errs++;
                if (errs < 10)
                    $display("FAIL timebase rel=%0d: got us=%b ms=%b required us=%b ms=%b",
                             rel, pulse_1us, pulse_1ms, exp_us, exp_ms);
            end
        end
        for (int it = 0; it < 4; it++) begin
            int d;
            d = (it == 0) ? 0 : int'($urandom_range(1, 7));
            bus_wr(5'd0, 32'(d), pw);
            for (int c = 0; c < 40; c++) begin
                int rel;
                logic exp_us;
                @(posedge mclk);
                #1;
                rel    = cyc - pw;
                exp_us = ((rel % (d + 1)) == d);
                n_cmp++;
                if (pulse_1us !== exp_us) begin
                    n_err++;
                    $display("FAIL timebase_div%0d rel=%0d: got %b required %b", d, rel, pulse_1us, exp_us);
                end
            end
        end
        $display("test_timebase done");
    endtask

    task automatic test_periodic();
        int e;
        int pb;
        int at;
        do_reset();
        bus_wr(5'd5, 32'd3, e);
        bus_wr(5'd2, 32'd1, e);
        bus_wr(5'd4, 32'd3, pb);
        for (int m = 1; m <= 3; m++) begin
            wait_rise(0, 50, at);
            n_cmp++;
            if (at !== pb + 4 * m + 1) begin
                n_err++;
                $display("FAIL periodic_intr%0d: got edge %0d required %0d", m, at - pb, 4 * m + 1);
            end
            $display("periodic expiry %0d intr at rel edge %0d", m, at - pb);
            bus_wr(5'd1, 32'd1, e);
        end
        $display("test_periodic done");
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        int e;
        int pw;
        int pb;
        int t;
        int at;
        do_reset();
        bus_wr(5'd0, 32'd4, pw);
        bus_wr(5'd7, 32'd10, e);
        bus_wr(5'd2, 32'd2, e);
        bus_wr(5'd6, 32'd9, pb);
        t = pw + 5;
        while (t <= pb) t += 5;
        t += 50;
        wait_rise(1, 300, at);
        n_cmp++;
        if (at !== t + 1) begin
            n_err++;
            $display("FAIL oneshot_intr: got edge %0d required %0d", at, t + 1);
        end
        bus_rd(5'd6, d, e);
        n_cmp++;
        if (d !== 32'd8) begin
            n_err++;
            $display("FAIL oneshot_tcfg: got %h required 8", d);
        end
        bus_rd(5'd7, d, e);
        n_cmp++;
        if (d !== 32'd0) begin
            n_err++;
            $display("FAIL oneshot_count: got %h required 0", d);
        end
        bus_wr(5'd1, 32'd2, e);
        repeat (100) @(posedge mclk);
        bus_rd(5'd1, d, e);
        n_cmp++;
        if (d !== 32'd0 || timer_intr !== 4'd0) begin
            n_err++;
            $display("FAIL oneshot_single: got stat=%h intr=%b required 0/0000", d, timer_intr);
        end
        $display("test_oneshot done");
    endtask

    task automatic test_collision();
        logic [31:0] d;
        int e;
        int pb;
        int w;
        int r;
        do_reset();
        bus_wr(5'd5, 32'd3, e);
        bus_wr(5'd4, 32'd3, pb);
        repeat (7) @(posedge mclk);
        bus_wr(5'd1, 32'd1, w);
        bus_rd(5'd1, d, r);
        n_cmp++;
        if (d[0] !== stat_after(pb, 4, w, r) || ((w - pb) % 4) != 0) begin
            n_err++;
            $display("FAIL collision_w1c: got stat0=%b at w1c rel %0d required %b at a multiple of 4",
                     d[0], w - pb, stat_after(pb, 4, w, r));
        end
        repeat (2) @(posedge mclk);
        bus_wr(5'd1, 32'd1, w);
        bus_rd(5'd1, d, r);
        n_cmp++;
        if (d[0] !== stat_after(pb, 4, w, r)) begin
            n_err++;
            $display("FAIL collision_second_w1c: got stat0=%b required %b", d[0], stat_after(pb, 4, w, r));
        end
        $display("test_collision done");
    endtask

    task automatic test_bus();
        logic [31:0] d;
        logic        a;
        int          e;
        int          acks;
        do_reset();
        bus_access(1'b0, 5'h1F, 32'd0, d, a, e);
        n_cmp++;
        if (d !== 32'd0 || a !== 1'b1) begin
            n_err++;
            $display("FAIL bus_unmapped: got data=%h ack=%b required 0/1", d, a);
        end
        bus_wr(5'd12, 32'h1F, e);
        bus_rd(5'd12, d, e);
        n_cmp++;
        if (d !== 32'd0) begin
            n_err++;
            $display("FAIL bus_absent_timer: got %h required 0", d);
        end
        bus_wr(5'd2, 32'hFF, e);
        bus_rd(5'd2, d, e);
        n_cmp++;
        if (d !== 32'hF) begin
            n_err++;
            $display("FAIL bus_mask_width: got %h required f", d);
        end
        bus_wr(5'd5, 32'hFFFF_FFFF, e);
        bus_rd(5'd5, d, e);
        n_cmp++;
        if (d !== 32'h00FF_FFFF) begin
            n_err++;
            $display("FAIL bus_tval_width: got %h required 00ffffff", d);
        end
        @(negedge mclk);
        bus_if.reg_cs = 1'b1; bus_if.reg_wr = 1'b0; bus_if.reg_addr = 5'd0;
        acks = 0;
        repeat (4) begin
            @(posedge mclk);
            #1;
            if (bus_if.reg_ack) acks++;
        end
        @(negedge mclk);
        bus_if.reg_cs = 1'b0;
        n_cmp++;
        if (acks !== 2) begin
            n_err++;
            $display("FAIL bus_held_cs: got %0d acks required 2", acks);
        end
        $display("test_bus done");
    endtask

    task automatic test_random();
        logic [31:0] d;
        int e;
        for (int it = 0; it < 10; it++) begin
            int i;
            int mode;
            int ld;
            int dly;
            int pb;
            int pr;
            longint expc;
            logic exp_en;
            do_reset();
            i    = int'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 3));
            ld   = int'($urandom_range(0, 20));
            dly  = int'($urandom_range(0, 40));
            bus_wr(5'(5 + 2 * i), 32'(ld), e);
            bus_wr(5'(4 + 2 * i), 32'(1 | (mode << 1)), pb);
            repeat (dly) @(posedge mclk);
            bus_rd(5'(5 + 2 * i), d, pr);
            expc = exp_count(mode, longint'(ld), longint'(pr - pb - 1));
            n_cmp++;
            if (d !== 32'(expc)) begin
                n_err++;
                $display("FAIL random_count t%0d mode%0d load%0d n%0d: got %h required %h",
                         i, mode, ld, pr - pb - 1, d, 32'(expc));
            end
            bus_rd(5'(4 + 2 * i), d, pr);
            exp_en = (mode == 1 || mode == 2) ? 1'b1 : ((pr - pb - 1) <= ld);
            n_cmp++;
            if (d !== 32'({mode[1:0], exp_en})) begin
                n_err++;
                $display("FAIL random_tcfg t%0d mode%0d: got %h required %h", i, mode, d, 32'({mode[1:0], exp_en}));
            end
            bus_rd(5'd1, d, pr);
            n_cmp++;
            if (d !== (((pr - pb - 1) >= ld + 1) ? (32'd1 << i) : 32'd0)) begin
                n_err++;
                $display("FAIL random_stat t%0d load%0d n%0d: got %h", i, ld, pr - pb - 1, d);
            end
            $display("random it%0d timer%0d mode%0d load%0d delay%0d checked", it, i, mode, ld, dly);
        end
    endtask

    initial begin
        bus_if.reg_cs    = 1'b0;
        bus_if.reg_wr    = 1'b0;
        bus_if.reg_addr  = 5'd0;
        bus_if.reg_wdata = 32'd0;
        bus_if.reg_be    = 4'h0;
        test_reset();
        test_timebase();
        test_periodic();
        test_oneshot();
        test_collision();
        test_bus();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
